// File: rtl/ac2_if.sv
// ac2_if: beat input and result output of the shift-accumulate bank.
// Build option AC2_EARLY_LAST_EN adds the 'last' early-completion flag.
interface ac2_if #(
  parameter int IW = 13,
  parameter int AW = 17,
  parameter int CW = 2
);
  logic          valid;
  logic          in_ready;
  logic [IW-1:0] in_ac2;
  logic [CW-1:0] ch_sel;
`ifdef AC2_EARLY_LAST_EN
  logic          last;
`endif
  logic          cl_en;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ch;
  logic [AW-1:0] out_data;

  modport master (
    output valid, in_ac2, ch_sel, cl_en, out_ready,
`ifdef AC2_EARLY_LAST_EN
    output last,
`endif
    input  in_ready, out_valid, out_ch, out_data
  );

  modport slave (
    input  valid, in_ac2, ch_sel, cl_en, out_ready,
`ifdef AC2_EARLY_LAST_EN
    input  last,
`endif
    output in_ready, out_valid, out_ch, out_data
  );
endinterface

// File: rtl/ac2_bank.sv
// ac2_bank: NCH-channel Horner shift-accumulate bank for bit-serial weights.
// Each channel folds NSTEP signed digits (MSB first) into an AW-bit result
// and hands it to a single valid/ready output slot.
// Build option AC2_EARLY_LAST_EN: a beat with 'last' set completes its
// channel early (variable-precision weights of 1..NSTEP digits).
module ac2_bank #(
  parameter int M     = 16,
  parameter int Pa    = 8,
  parameter int Pw    = 4,
  parameter int NCH   = 4,
  parameter int NSTEP = 2
) (
  input logic  clk,
  input logic  rst,
  ac2_if.slave bus
);
  localparam int IW = $clog2(M) + Pa + 1;
  localparam int AW = IW + Pw * (NSTEP - 1);
  localparam int CW = $clog2(NCH);
  localparam int SW = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [SW-1:0] LAST_CNT = SW'(NSTEP - 1);

  logic signed [AW-1:0] acc [NCH];
  logic        [SW-1:0] cnt [NCH];

  logic                 out_valid_q;
  logic        [AW-1:0] out_data_q;
  logic        [CW-1:0] out_ch_q;

  logic                 in_ready_c;
  logic                 accept;
  logic                 complete;
  logic                 early_last;
  logic signed [AW-1:0] sx;
  logic signed [AW-1:0] acc_cur;
  logic        [SW-1:0] cnt_cur;
  logic signed [AW-1:0] sum;

  // Backpressure: every beat stalls while the result slot cannot be freed,
  // so a completing beat never finds the slot occupied.
  always_comb begin
    in_ready_c = !rst && !bus.cl_en && (!out_valid_q || bus.out_ready);
    accept     = bus.valid && in_ready_c;
  end

  // Select the addressed channel and fold in the new digit.
  always_comb begin
    acc_cur = acc[bus.ch_sel];
    cnt_cur = cnt[bus.ch_sel];
    sx      = AW'($signed(bus.in_ac2));
    if (cnt_cur == '0) begin
      sum = sx;
    end else begin
      sum = (acc_cur <<< Pw) + sx;
    end
`ifdef AC2_EARLY_LAST_EN
    early_last = bus.last;
`else
    early_last = 1'b0;
`endif
    complete = (cnt_cur == LAST_CNT) || early_last;
  end

  // Per-channel partial sums; cleared by reset or cl_en, recycled on completion.
  always_ff @(posedge clk) begin
    if (rst || bus.cl_en) begin
      for (int i = 0; i < NCH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else if (accept) begin
      if (complete) begin
        acc[bus.ch_sel] <= '0;
        cnt[bus.ch_sel] <= '0;
      end else begin
        acc[bus.ch_sel] <= sum;
        cnt[bus.ch_sel] <= cnt_cur + 1'b1;
      end
    end
  end

  // Result slot: a completing beat reloads it even while it is being drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else if (accept && complete) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sum;
      out_ch_q    <= bus.ch_sel;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
endmodule

// File: tb/tb_ac2_bank.sv
// tb_ac2_bank: directed vectors for ac2_bank (NSTEP=2 instance) plus
// hand-written sequences for an NSTEP=4 instance. Exercises the
// AC2_EARLY_LAST_EN path when that macro is defined.
module tb_ac2_bank;
  localparam int IW  = 13;
  localparam int AW  = 17;
  localparam int AW4 = 25;
  localparam int CW  = 2;

  typedef struct {
    int rs, v, d, ch, cl, ordy;
    int e_rdy, e_ov, e_od, e_och;
  } vec_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  vec_t vt[$];

  ac2_if #(.IW(IW), .AW(AW),  .CW(CW)) bus();
  ac2_if #(.IW(IW), .AW(AW4), .CW(CW)) bus4();

  ac2_bank u_dut  (.clk(clk), .rst(rst), .bus(bus));
  ac2_bank #(.NSTEP(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step4(string nm, int d, int ch, int e_ov, int e_od);
    bus4.valid  = 1'b1;
    bus4.in_ac2 = IW'(d);
    bus4.ch_sel = CW'(ch);
    #1;
    chk({nm, " in_ready"}, int'(bus4.in_ready), 1);
    @(posedge clk);
    #1;
    bus4.valid = 1'b0;
    chk({nm, " out_valid"}, int'(bus4.out_valid), e_ov);
    if (e_ov != 0) begin
      chk({nm, " out_data"}, int'($signed(bus4.out_data)), e_od);
      chk({nm, " out_ch"}, int'(bus4.out_ch), ch);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    bus.valid = 1'b0;  bus.in_ac2 = '0;  bus.ch_sel = '0;
    bus.cl_en = 1'b0;  bus.out_ready = 1'b1;
    bus4.valid = 1'b0; bus4.in_ac2 = '0; bus4.ch_sel = '0;
    bus4.cl_en = 1'b0; bus4.out_ready = 1'b1;
`ifdef AC2_EARLY_LAST_EN
    bus.last  = 1'b0;
    bus4.last = 1'b0;
`endif

    //            rs v  d     ch cl ordy  rdy ov od      och
    vt.push_back('{1, 0, 0,    0, 0, 1,    0,  0, 0,      0});
    vt.push_back('{1, 1, 3,    0, 0, 1,    0,  0, 0,      0});
    // ch0 3,5 -> 53
    vt.push_back('{0, 1, 3,    0, 0, 1,    1,  0, 0,      0});
    vt.push_back('{0, 1, 5,    0, 0, 1,    1,  1, 53,     0});
    // ch1 -2 ... 7 with ch2 1,1 interleaved
    vt.push_back('{0, 1, -2,   1, 0, 1,    1,  0, 0,      0});
    vt.push_back('{0, 1, 1,    2, 0, 1,    1,  0, 0,      0});
    vt.push_back('{0, 1, 1,    2, 0, 1,    1,  1, 17,     2});
    vt.push_back('{0, 1, 7,    1, 0, 1,    1,  1, -25,    1});
    vt.push_back('{0, 0, 0,    0, 0, 1,    1,  0, 0,      0});
    // stall with slot full, then drain and accept in the same cycle
    vt.push_back('{0, 1, 3,    0, 0, 1,    1,  0, 0,      0});
    vt.push_back('{0, 1, 4,    0, 0, 0,    1,  1, 52,     0});
    vt.push_back('{0, 1, 6,    1, 0, 0,    0,  1, 52,     0});
    vt.push_back('{0, 1, 6,    1, 0, 0,    0,  1, 52,     0});
    vt.push_back('{0, 1, 6,    1, 0, 1,    1,  0, 0,      0});
    vt.push_back('{0, 1, 2,    1, 0, 1,    1,  1, 98,     1});
    vt.push_back('{0, 0, 0,    0, 0, 1,    1,  0, 0,      0});
    // ch3 9, clear, then 2,4 -> 36
    vt.push_back('{0, 1, 9,    3, 0, 1,    1,  0, 0,      0});
    vt.push_back('{0, 1, 5,    3, 1, 1,    0,  0, 0,      0});
    vt.push_back('{0, 1, 2,    3, 0, 1,    1,  0, 0,      0});
    vt.push_back('{0, 1, 4,    3, 0, 1,    1,  1, 36,     3});
    vt.push_back('{0, 0, 0,    0, 0, 1,    1,  0, 0,      0});
    // range extremes
    vt.push_back('{0, 1, -4096, 0, 0, 1,   1,  0, 0,      0});
    vt.push_back('{0, 1, 0,    0, 0, 1,    1,  1, -65536, 0});
    vt.push_back('{0, 1, 4095, 2, 0, 1,    1,  0, 0,      0});
    vt.push_back('{0, 1, 15,   2, 0, 1,    1,  1, 65535,  2});
    vt.push_back('{0, 0, 0,    0, 0, 1,    1,  0, 0,      0});
    // clear leaves a pending result alone
    vt.push_back('{0, 1, 1,    1, 0, 1,    1,  0, 0,      0});
    vt.push_back('{0, 1, 1,    1, 0, 0,    1,  1, 17,     1});
    vt.push_back('{0, 0, 0,    0, 1, 0,    0,  1, 17,     1});
    vt.push_back('{0, 0, 0,    0, 0, 1,    1,  0, 0,      0});
    // reset mid-sequence discards the partial sum
    vt.push_back('{0, 1, 7,    0, 0, 1,    1,  0, 0,      0});
    vt.push_back('{1, 1, 9,    0, 0, 1,    0,  0, 0,      0});
    vt.push_back('{0, 1, 2,    0, 0, 1,    1,  0, 0,      0});
    vt.push_back('{0, 1, 3,    0, 0, 1,    1,  1, 35,     0});
    // reset drops a pending result
    vt.push_back('{0, 1, 1,    1, 0, 1,    1,  0, 0,      0});
    vt.push_back('{0, 1, 1,    1, 0, 0,    1,  1, 17,     1});
    vt.push_back('{1, 0, 0,    0, 0, 0,    0,  0, 0,      0});
    vt.push_back('{0, 1, 5,    1, 0, 1,    1,  0, 0,      0});
    vt.push_back('{0, 1, 6,    1, 0, 1,    1,  1, 86,     1});
    vt.push_back('{0, 0, 0,    0, 0, 1,    1,  0, 0,      0});

    for (int i = 0; i < vt.size(); i++) begin
      rst           = (vt[i].rs != 0);
      bus.valid     = (vt[i].v != 0);
      bus.in_ac2    = IW'(vt[i].d);
      bus.ch_sel    = CW'(vt[i].ch);
      bus.cl_en     = (vt[i].cl != 0);
      bus.out_ready = (vt[i].ordy != 0);
      #1;
      chk($sformatf("v%0d in_ready", i), int'(bus.in_ready), vt[i].e_rdy);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), int'(bus.out_valid), vt[i].e_ov);
      if (vt[i].e_ov != 0 || vt[i].rs != 0) begin
        chk($sformatf("v%0d out_data", i), int'($signed(bus.out_data)), vt[i].e_od);
        chk($sformatf("v%0d out_ch", i), int'(bus.out_ch), vt[i].e_och);
      end
    end
    rst       = 1'b0;
    bus.valid = 1'b0;
    bus.cl_en = 1'b0;
    bus.out_ready = 1'b1;

    // -25 as 17-bit two's complement is 0x1FFE7
    bus.valid = 1'b1; bus.ch_sel = 2'd1; bus.in_ac2 = IW'(-2);
    @(posedge clk); #1;
    bus.in_ac2 = IW'(7);
    @(posedge clk); #1;
    bus.valid = 1'b0;
    chk("raw -25", int'(bus.out_data), 32'h1FFE7);

    // NSTEP=4: digits 1,0,0,-1 -> 4095
    step4("n4 d0", 1, 0, 0, 0);
    step4("n4 d1", 0, 0, 0, 0);
    step4("n4 d2", 0, 0, 0, 0);
    step4("n4 d3", -1, 0, 1, 4095);
    step4("n4 ch3 d0", 2, 3, 0, 0);
    step4("n4 ch1 d0", 1, 1, 0, 0);
    step4("n4 ch3 d1", 0, 3, 0, 0);
    step4("n4 ch1 d1", 0, 1, 0, 0);
    step4("n4 ch3 d2", 0, 3, 0, 0);
    step4("n4 ch1 d2", 0, 1, 0, 0);
    step4("n4 ch3 d3", 1, 3, 1, 8193);
    step4("n4 ch1 d3", -1, 1, 1, 4095);

`ifdef AC2_EARLY_LAST_EN
    // early completion: 2,3(last) -> 35, then a fresh 4-digit sequence
    step4("el d0", 2, 0, 0, 0);
    bus4.last = 1'b1;
    step4("el d1 last", 3, 0, 1, 35);
    bus4.last = 1'b0;
    step4("el n d0", 1, 0, 0, 0);
    step4("el n d1", 0, 0, 0, 0);
    step4("el n d2", 0, 0, 0, 0);
    step4("el n d3", -1, 0, 1, 4095);
    bus4.last = 1'b1;
    step4("el single", -9, 2, 1, -9);
    bus4.last = 1'b0;
    bus.last = 1'b1;
    bus.valid = 1'b1; bus.ch_sel = 2'd0; bus.in_ac2 = IW'(5);
    @(posedge clk); #1;
    bus.valid = 1'b0; bus.last = 1'b0;
    chk("el2 single valid", int'(bus.out_valid), 1);
    chk("el2 single data", int'($signed(bus.out_data)), 5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ac2_bank.md
# ac2_bank

Multi-channel, parametrised shift-accumulate bank for bit-serial weight processing in the dot-product datapath. It receives signed partial sums (one Pw-bit weight digit per beat, MSB digit first) from the negation/adder stage and holds up to NCH independent accumulation channels. Each channel combines NSTEP digits Horner-style, then emits the completed result through a single valid/ready output slot. It replaces the fixed four-register accumulator with configurable channel count, digit count, per-channel sequencing and flow control.

## Interface
- M, 16: number of products summed upstream; sets input growth.
- Pa, 8: activation operand width.
- Pw, 4: weight digit width; shift per step.
- NCH, 4: number of accumulation channels (≥2, power of two).
- NSTEP, 2: digits per weight (≥1).
- Derived: IW = $clog2(M)+Pa+1; AW = IW+Pw*(NSTEP-1).

- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- valid  in  1  input beat present.
- in_ready  out  1  beat accepted when valid && in_ready.
- in_ac2  in  IW  signed partial sum for the current digit.
- ch_sel  in  $clog2(NCH)  target channel of the beat.
- last  in  1  early completion flag (present only with AC2_EARLY_LAST_EN).
- cl_en  in  1  clear all channels.
- out_valid  out  1  result slot full.
- out_ready  in  1  consumer takes result when out_valid && out_ready.
- out_ch  out  $clog2(NCH)  channel of the result.
- out_data  out  AW  signed completed accumulation.

## Operation
- Per channel c: acc[c] (AW bits, signed), cnt[c] (digits accepted, 0..NSTEP-1).
- Accepted beat on channel c, sx = sign-extend(in_ac2) to AW:
  - cnt[c]==0: sum = sx.
  - else: sum = (acc[c] << Pw) + sx, truncated to AW (two's-complement wrap; cannot overflow for in-range inputs).
- Completing beat: cnt[c]==NSTEP-1 (or last=1 when enabled). Loads out_data=sum, out_ch=c, out_valid=1; acc[c]<=0, cnt[c]<=0.
- Non-completing beat: acc[c]<=sum, cnt[c]<=cnt[c]+1.
- Beats to different channels may interleave arbitrarily; each channel keeps independent state.
- in_ready = !rst && !cl_en && (!out_valid || out_ready). Held low for all beats (not only completing ones) while slot is blocked.
- Output slot: out_valid clears on out_ready unless a completing beat reloads it in the same cycle (reload wins; out_valid stays 1).
- cl_en: next edge sets all acc and cnt to 0; output slot untouched; no beat accepted that cycle.
- NSTEP==1: every beat completes; acc never written.

## Timing
- Reset: out_valid=0, out_data=0, out_ch=0, all acc=0, all cnt=0; in_ready=0 while rst high.
- Latency: completing beat accepted at edge k -> out_valid/out_data valid after edge k (1 cycle).
- Throughput: one beat per cycle with out_ready held high.
- out_data/out_ch stable while out_valid && !out_ready.
- rst mid-sequence discards all partial sums and any pending result.

## Configuration
- AC2_EARLY_LAST_EN defined: `last` port exists; an accepted beat with last=1 completes its channel regardless of cnt (variable-precision weights, 1..NSTEP digits). A last=1 beat when cnt==0 outputs sx directly.
- Undefined: no `last` port; completion only at cnt==NSTEP-1.

## Test plan
- Defaults; reset, then ch0 beats 3, 5 with out_ready=1 -> out_valid one cycle after second beat, out_data=53, out_ch=0.
- ch1 beats -2, 7 -> out_data=-25 (AW=17, 0x1FFE7); interleave ch2 beats 1, 1 between them -> ch2 result 17, ch1 result -25, both correct.
- out_ready=0 with slot full -> in_ready=0, valid beats stall, out_data holds; release out_ready -> result drains and stalled beat accepted same cycle.
- ch3 beat 9, then cl_en, then ch3 beats 2, 4 -> out_data=36 (first digit discarded).
- NSTEP=4, ch0 digits 1,0,0,-1 -> out_data=4095.
- AC2_EARLY_LAST_EN, NSTEP=4: ch0 digits 2, 3 with last on second -> out_data=35; next ch0 sequence starts at cnt=0.
